// File: rtl/iterative_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op codes, FSM states, default width and iteration-counter width.
package md_pkg;

  localparam int XLEN_DEFAULT = 32;
  // One iteration per result bit, so the counter spans 0..XLEN-1.
  localparam int CNT_W = $clog2(XLEN_DEFAULT);

  // Op codes equal the RV32M funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_fn_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  // Divide and remainder ops all have funct3[2] set.
  function automatic logic is_div(input md_fn_e fn);
    return fn[2];
  endfunction

  // Remainder ops have funct3[1] set within the divide group.
  function automatic logic is_rem(input md_fn_e fn);
    return fn[2] & fn[1];
  endfunction

  function automatic logic signed_a(input md_fn_e fn);
    return fn inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic signed_b(input md_fn_e fn);
    return fn inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/iterative_muldiv_if.sv
// Request/response/kill bundle between the execute stage and the muldiv unit.
interface iterative_muldiv_if #(
  parameter int XLEN = md_pkg::XLEN_DEFAULT
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_fn;
  logic [XLEN-1:0] req_op_a;
  logic [XLEN-1:0] req_op_b;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  // Pipeline side issuing ops and consuming results.
  modport master (
    output req_valid, req_fn, req_op_a, req_op_b, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  // The muldiv unit itself.
  modport slave (
    input  req_valid, req_fn, req_op_a, req_op_b, kill, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/iterative_muldiv_sign_fix.sv
// Conditional two's-complement negation: absolute value of a signed operand
// at accept, or sign restoration of the result at FIXUP.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);
  assign result = negate ? (~value + W'(1)) : value;
endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide: one bit per cycle on operand magnitudes,
// sign fix-up at the end, result held until the writeback side accepts it.
module iterative_muldiv
  import md_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  iterative_muldiv_if.slave  io_md
);

  md_state_e         state, state_next;
  md_fn_e            fn_q;
  md_fn_e            req_fn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   resp_data_q;

  logic              accept, div_by_zero, overflow, special;
  logic [XLEN-1:0]   abs_a, abs_b, special_result, fixup_result;
  logic [CNT_W-1:0]  bit_idx;
  logic [2*XLEN-1:0] mul_step, div_step, fix_in, fix_out;
  logic [XLEN:0]     rem_shift;
  logic              rem_ge;
  logic              fix_neg;

  assign req_fn = md_fn_e'(io_md.req_fn);
  assign accept = (state == MD_IDLE) && io_md.req_valid && !io_md.kill;

  // Magnitudes of the incoming operands; sign flags latch alongside them.
  muldiv_sign_fix #(.W(XLEN)) u_abs_a (
    .value (io_md.req_op_a),
    .negate(signed_a(req_fn) & io_md.req_op_a[XLEN-1]),
    .result(abs_a)
  );
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (
    .value (io_md.req_op_b),
    .negate(signed_b(req_fn) & io_md.req_op_b[XLEN-1]),
    .result(abs_b)
  );

  // Divide special cases are resolved in the accept cycle and skip iteration.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    special_result = '0;
    div_by_zero    = is_div(req_fn) && (io_md.req_op_b == '0);
    overflow       = (req_fn == MD_DIV || req_fn == MD_REM)
                     && (io_md.req_op_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (io_md.req_op_b == '1);
    if (div_by_zero)
      special_result = is_rem(req_fn) ? io_md.req_op_a : '1;
    else if (overflow)
      special_result = is_rem(req_fn) ? '0 : io_md.req_op_a;
  end
  assign special = div_by_zero | overflow;

  // One MSB-first iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    bit_idx   = CNT_W'(XLEN-1) - cnt;
    mul_step  = {acc[2*XLEN-2:0], 1'b0}
                + (b_mag[bit_idx] ? {{XLEN{1'b0}}, a_mag} : '0);
    rem_shift = {acc[2*XLEN-1:XLEN], a_mag[bit_idx]};
    rem_ge    = rem_shift >= {1'b0, b_mag};
    div_step  = {(rem_ge ? XLEN'(rem_shift - {1'b0, b_mag}) : rem_shift[XLEN-1:0]),
                 acc[XLEN-2:0], rem_ge};
  end

  // Sign restoration: products and quotients take sign_a^sign_b, remainders sign_a.
  always_comb begin
    fix_in  = acc;
    fix_neg = sign_a ^ sign_b;
    if (is_rem(fn_q)) begin
      fix_in  = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]};
      fix_neg = sign_a;
    end else if (is_div(fn_q)) begin
      fix_in  = {{XLEN{1'b0}}, acc[XLEN-1:0]};
    end
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_res (
    .value (fix_in),
    .negate(fix_neg),
    .result(fix_out)
  );

  assign fixup_result = (fn_q == MD_MUL || is_div(fn_q)) ? fix_out[XLEN-1:0]
                                                         : fix_out[2*XLEN-1:XLEN];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; kill returns any busy state to IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      MD_IDLE:  if (accept) state_next = special ? MD_DONE : MD_CALC;
      MD_CALC:  if (io_md.kill) state_next = MD_IDLE;
                else if (cnt == CNT_W'(XLEN-1)) state_next = MD_FIXUP;
      MD_FIXUP: state_next = io_md.kill ? MD_IDLE : MD_DONE;
      MD_DONE:  if (io_md.kill || io_md.resp_ready) state_next = MD_IDLE;
      default:  state_next = MD_IDLE;
    endcase
  end

  // Outputs are pure decodes of state, so reset drives them without a clock.
  always_comb begin
    io_md.req_ready  = (state == MD_IDLE);
    io_md.resp_valid = (state == MD_DONE);
    io_md.busy       = (state != MD_IDLE);
    io_md.resp_data  = resp_data_q;
  end

  // Datapath: latch operands at accept, iterate in CALC, register the result.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: all datapath registers are reset too, so an aborted op leaves nothing behind.
    if (!reset_n) begin
      fn_q        <= MD_MUL;
      a_mag       <= '0;
      b_mag       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      resp_data_q <= '0;
    end else if (accept) begin
      fn_q   <= req_fn;
      a_mag  <= abs_a;
      b_mag  <= abs_b;
      sign_a <= signed_a(req_fn) & io_md.req_op_a[XLEN-1];
      sign_b <= signed_b(req_fn) & io_md.req_op_b[XLEN-1];
      acc    <= '0;
      cnt    <= '0;
      if (special) resp_data_q <= special_result;
    end else if (state == MD_CALC) begin
      acc <= is_div(fn_q) ? div_step : mul_step;
      cnt <= cnt + CNT_W'(1);
    end else if (state == MD_FIXUP && !io_md.kill) begin
      resp_data_q <= fixup_result;
    end
  end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Self-checking bench for iterative_muldiv: directed RV32M corner cases,
// backpressure, kill and async reset, plus randomized ops against an
// arithmetic reference model.
module tb_iterative_muldiv;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  iterative_muldiv_if #(.XLEN(32)) io_md ();

  iterative_muldiv #(.XLEN(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_md  (io_md)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = signed'(a);
    ib = signed'(b);
    case (fn)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (fn < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (fn == 3'd4 || fn == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op, measure edges from the accept edge until resp_valid is seen,
  // optionally stall the response, then complete the handshake.
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] exp;
    int          lat, exp_lat;
    bit          busy_ok, stable_ok;
    exp     = ref_model(fn, a, b);
    exp_lat = is_special(fn, a, b) ? 0 : 33;
    check({tag, ":req_ready"}, io_md.req_ready, 1);
    io_md.req_valid = 1'b1;
    io_md.req_fn    = fn;
    io_md.req_op_a  = a;
    io_md.req_op_b  = b;
    @(posedge clk); #1;
    io_md.req_valid = 1'b0;
    io_md.req_fn    = 3'($urandom);
    io_md.req_op_a  = $urandom;
    io_md.req_op_b  = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!io_md.resp_valid && lat < 100) begin
      if (!io_md.busy || io_md.req_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":busy"}, {busy_ok, io_md.busy}, 2'b11);
    check({tag, ":data"}, io_md.resp_data, exp);
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (io_md.resp_valid !== 1'b1 || io_md.resp_data !== exp || io_md.req_ready !== 1'b0)
          stable_ok = 1'b0;
      end
      check({tag, ":hold_stable"}, stable_ok, 1);
    end
    io_md.resp_ready = 1'b1;
    @(posedge clk); #1;
    io_md.resp_ready = 1'b0;
    check({tag, ":after_hs"}, {io_md.req_ready, io_md.resp_valid, io_md.busy}, 3'b100);
    check({tag, ":data_kept"}, io_md.resp_data, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    io_md.req_valid  = 1'b0;
    io_md.req_fn     = 3'd0;
    io_md.req_op_a   = '0;
    io_md.req_op_b   = '0;
    io_md.kill       = 1'b0;
    io_md.resp_ready = 1'b0;

    #12;
    check("reset_outputs", {io_md.req_ready, io_md.resp_valid, io_md.busy}, 3'b100);
    check("reset_data", io_md.resp_data, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5, "mul_7_m3");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, "mulhsu_m1");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0, "rem_m7_2");
    run_op(3'd5, 32'd100,        32'd7,         0, "divu_100_7");
    run_op(3'd7, 32'd100,        32'd7,         0, "remu_100_7");
    run_op(3'd4, 32'd5,          32'd0,         0, "div_by0");
    run_op(3'd6, 32'd5,          32'd0,         2, "rem_by0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, "rem_ovf");

    // Kill on the 10th CALC cycle.
    io_md.req_valid = 1'b1;
    io_md.req_fn    = 3'd0;
    io_md.req_op_a  = 32'd123;
    io_md.req_op_b  = 32'd456;
    @(posedge clk); #1;
    io_md.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("kill:busy_before", io_md.busy, 1);
    io_md.kill = 1'b1;
    @(posedge clk); #1;
    io_md.kill = 1'b0;
    check("kill:idle_next", {io_md.req_ready, io_md.busy}, 2'b10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (io_md.resp_valid) seen = 1'b1;
    end
    check("kill:no_resp", seen, 0);

    // Kill together with a request in IDLE: the request is dropped.
    io_md.req_valid = 1'b1;
    io_md.kill      = 1'b1;
    io_md.req_fn    = 3'd5;
    io_md.req_op_b  = 32'd0;
    @(posedge clk); #1;
    io_md.req_valid = 1'b0;
    io_md.kill      = 1'b0;
    check("kill_req:not_accepted", {io_md.req_ready, io_md.busy, io_md.resp_valid}, 3'b100);

    // Randomized ops.
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), pick_operand(), pick_operand(), $urandom_range(0, 3),
             $sformatf("rand%0d", i));

    // Asynchronous reset in the middle of CALC.
    io_md.req_valid = 1'b1;
    io_md.req_fn    = 3'd5;
    io_md.req_op_a  = 32'd1000;
    io_md.req_op_b  = 32'd3;
    @(posedge clk); #1;
    io_md.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("areset:busy_before", io_md.busy, 1);
    reset_n = 1'b0;
    #1;
    check("areset:outputs", {io_md.req_ready, io_md.resp_valid, io_md.busy}, 3'b100);
    check("areset:data", io_md.resp_data, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (io_md.resp_valid || !io_md.req_ready) seen = 1'b1;
    end
    check("areset:no_resp", seen, 0);

    run_op(3'd7, 32'd100, 32'd7, 0, "post_reset_remu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
